// File: rtl/lsu_bus_if.sv
// Multi-cycle load/store unit: valid/ready request plus read-response handshake to data memory,
// core stall, byte strobes, lane replication, load extension, misalignment and timeout handling.
module lsu_bus_if #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  store_sz,
  input  logic [2:0]  load_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, wdata_q, rdata_q, rdata_d;
  logic [1:0]        size_q;
  logic [2:0]        sel_q;
  logic              we_q, err_q, err_d;

  // Access size encoding: 0 byte, 1 half, 2 word.
  logic [1:0] ld_size, st_size, acc_size;
  logic       access, aligned, go, timeout_hit;

  always_comb begin
    unique case (load_sel)
      3'b000, 3'b011: ld_size = 2'd0;
      3'b001, 3'b100: ld_size = 2'd1;
      default:        ld_size = 2'd2;
    endcase
    unique case (store_sz)
      2'b00:   st_size = 2'd0;
      2'b01:   st_size = 2'd1;
      default: st_size = 2'd2;
    endcase
    acc_size = mem_write ? st_size : ld_size;
    access   = mem_read | mem_write;
    unique case (acc_size)
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    go          = (state_q == StIdle) && access && aligned;
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else if (go) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      size_q  <= acc_size;
      sel_q   <= load_sel;
      we_q    <= mem_write;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StReq;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      StReq: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_gnt) begin
          if (we_q) begin
            state_d = StDone;
          end else if (bus_rvalid) begin
            rdata_d = bus_rdata;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (sel_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b011:  ld_ext = {24'b0, ld_byte};
      3'b100:  ld_ext = {16'b0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wstrb  = '0;
    bus_wdata  = '0;
    rdata_ext  = '0;
    unique case (state_q)
      StIdle: begin
        stall      = go;
        misaligned = access && !aligned;
      end
      StReq: begin
        stall    = 1'b1;
        bus_req  = 1'b1;
        bus_we   = we_q;
        bus_addr = {addr_q[31:2], 2'b00};
        unique case (size_q)
          2'd0: begin
            bus_wdata = {4{wdata_q[7:0]}};
            bus_wstrb = we_q ? (4'b0001 << addr_q[1:0]) : 4'b0000;
          end
          2'd1: begin
            bus_wdata = {2{wdata_q[15:0]}};
            bus_wstrb = we_q ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0000;
          end
          default: begin
            bus_wdata = wdata_q;
            bus_wstrb = we_q ? 4'b1111 : 4'b0000;
          end
        endcase
      end
      StWait: stall = 1'b1;
      default: begin
        bus_err   = err_q;
        rdata_ext = (we_q || err_q) ? 32'b0 : ld_ext;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Scoreboard bench for lsu_bus_if: drives accesses with a programmable bus responder and compares
// latency, bus fields, extended load data and error pulses against a small bench-side model.
module tb_lsu_bus_if;

  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [1:0]  store_sz;
  logic [2:0]  load_sel;
  logic [31:0] addr, wdata;
  logic        stall, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] rdata_ext, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;

  lsu_bus_if #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .store_sz   (store_sz),
    .load_sel   (load_sel),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic run_access(input logic mr, input logic mw, input logic [1:0] ssz,
                            input logic [2:0] lsel, input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rdat,
                            input logic exp_mis, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    exp_t e, got;
    int   cyc, since_gnt, t;
    logic granted, done, ok;
    @(posedge clk); #1;
    mem_read = mr; mem_write = mw; store_sz = ssz; load_sel = lsel;
    addr = a; wdata = wd; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdat;
    #1;
    if (exp_mis) begin
      chk("mis_pulse", {31'b0, misaligned}, 32'd1);
      chk("mis_stall", {31'b0, stall}, 32'd0);
      chk("mis_req", {31'b0, bus_req}, 32'd0);
      chk("mis_rdata", rdata_ext, 32'd0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      chk("mis_clear", {31'b0, misaligned}, 32'd0);
      chk("mis_noreq", {31'b0, bus_req}, 32'd0);
      return;
    end
    chk("idle_stall", {31'b0, stall}, 32'd1);
    // Reference model: number of REQ/WAIT cycles and outcome.
    if (mw) begin
      ok  = gnt_dly < TO;
      e.n = ok ? gnt_dly + 1 : TO;
    end else begin
      t   = gnt_dly + rv_dly;
      ok  = (gnt_dly < NEVER) && (rv_dly < NEVER) && (t < TO);
      e.n = ok ? t + 1 : TO;
    end
    e.err = !ok;
    e.rd  = (!mw && ok) ? exp_rd : 32'd0;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    granted = 1'b0; since_gnt = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      bus_gnt    = !granted && (cyc == gnt_dly);
      bus_rvalid = !mw && (granted ? (since_gnt == rv_dly) : (bus_gnt && rv_dly == 0));
      #1;
      if (!stall) begin
        got = sb.pop_front();
        chk("latency", cyc, got.n);
        chk("rdata_ext", rdata_ext, got.rd);
        chk("bus_err", {31'b0, bus_err}, {31'b0, got.err});
        chk("done_req", {31'b0, bus_req}, 32'd0);
        done = 1'b1;
      end else begin
        chk("bus_req", {31'b0, bus_req}, {31'b0, !granted});
        if (!granted) begin
          chk("bus_addr", bus_addr, {a[31:2], 2'b00});
          chk("bus_we", {31'b0, bus_we}, {31'b0, mw});
          chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, exp_strb});
          if (mw) chk("bus_wdata", bus_wdata, exp_wd);
        end
        if (bus_gnt) granted = 1'b1;
      end
      @(posedge clk); #1;
      if (granted) since_gnt++;
      cyc++;
    end
    if (!done) begin
      chk("done_seen", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1;
    chk("idle_after", {30'b0, stall, bus_err}, 32'd0);
    chk("idle_rdata", rdata_ext, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; store_sz = 2'b00; load_sel = 3'b000;
    addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #1;
    chk("rst_outs", {27'b0, stall, misaligned, bus_err, bus_req, bus_we}, 32'd0);
    chk("rst_rdata", rdata_ext, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Stores: word, half, byte, size 11 as word
    run_access(0, 1, 2'b10, 3'b000, 32'h1000, 32'hDEADBEEF, 1, 0, 0, 0, 4'hF, 32'hDEADBEEF, 0);
    run_access(0, 1, 2'b01, 3'b000, 32'h3002, 32'h1234ABCD, 0, 0, 0, 0, 4'hC, 32'hABCDABCD, 0);
    run_access(0, 1, 2'b00, 3'b000, 32'h3001, 32'h1234ABCD, 2, 0, 0, 0, 4'h2, 32'hCDCDCDCD, 0);
    run_access(0, 1, 2'b11, 3'b000, 32'h3008, 32'h01020304, 0, 0, 0, 0, 4'hF, 32'h01020304, 0);
    // Loads with same-cycle and delayed responses
    run_access(1, 0, 2'b00, 3'b000, 32'h2003, 0, 0, 0, 32'h80FF7F01, 0, 4'h0, 0, 32'hFFFFFF80);
    run_access(1, 0, 2'b00, 3'b011, 32'h2003, 0, 0, 1, 32'h80FF7F01, 0, 4'h0, 0, 32'h00000080);
    run_access(1, 0, 2'b00, 3'b001, 32'h2002, 0, 1, 1, 32'h80FF7F01, 0, 4'h0, 0, 32'hFFFF80FF);
    run_access(1, 0, 2'b00, 3'b100, 32'h2002, 0, 0, 2, 32'h80FF7F01, 0, 4'h0, 0, 32'h000080FF);
    run_access(1, 0, 2'b00, 3'b000, 32'h2001, 0, 0, 0, 32'h80FF7F01, 0, 4'h0, 0, 32'h0000007F);
    run_access(1, 0, 2'b00, 3'b111, 32'h2000, 0, 0, 0, 32'h80FF7F01, 0, 4'h0, 0, 32'h80FF7F01);
    // Misaligned word load and half store
    run_access(1, 0, 2'b00, 3'b010, 32'h4001, 0, 0, 0, 0, 1, 4'h0, 0, 0);
    run_access(0, 1, 2'b01, 3'b000, 32'h4003, 0, 0, 0, 0, 1, 4'h0, 0, 0);
    // Timeouts: missing rvalid, missing gnt
    run_access(1, 0, 2'b00, 3'b010, 32'h5000, 0, 0, NEVER, 32'h55AA55AA, 0, 4'h0, 0, 0);
    run_access(1, 0, 2'b00, 3'b010, 32'h5000, 0, NEVER, 0, 32'h55AA55AA, 0, 4'h0, 0, 0);
    // Read and write together: store wins
    run_access(1, 1, 2'b10, 3'b010, 32'h7004, 32'hCAFEF00D, 0, 0, 0, 0, 4'hF, 32'hCAFEF00D, 0);

    // Reset while waiting for read data
    @(posedge clk); #1;
    mem_read = 1'b1; load_sel = 3'b010; addr = 32'h6000;
    @(posedge clk); #1;
    mem_read = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    #1;
    chk("wait_stall", {31'b0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {27'b0, stall, misaligned, bus_err, bus_req, bus_we}, 32'd0);
    chk("rst_mid_addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    #1;
    chk("late_rvalid_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    #1;
    chk("late_rvalid_outs", {30'b0, stall, bus_req}, 32'd0);
    chk("late_rvalid_rdata", rdata_ext, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
